// File: rtl/mem_write_buffer.sv
// mem_write_buffer: in-order store write buffer with youngest-match store-to-load forwarding.
// Latency: a store written at edge N drains/forwards from cycle N+1; lookup is combinational.
// Backpressure: enq_ready = !full (or coalescible match with WRITE_BUFFER_COALESCE_EN); head holds until drain_ready.
module mem_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [ADDR_WIDTH-1:0]   enq_addr,
  input  logic [DATA_WIDTH-1:0]   enq_data,
  input  logic [ID_WIDTH-1:0]     enq_id,
  output logic                    drain_valid,
  input  logic                    drain_ready,
  output logic [ADDR_WIDTH-1:0]   drain_addr,
  output logic [DATA_WIDTH-1:0]   drain_data,
  output logic [ID_WIDTH-1:0]     drain_id,
  input  logic                    ld_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    ld_hit,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic [ID_WIDTH-1:0]     ld_id,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ID_WIDTH-1:0]   mem_id   [DEPTH];
  logic [DEPTH-1:0]      mem_vld;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      wr_idx;

  logic enq_fire;
  logic drain_fire;
  logic enq_alloc;
  logic payload_wr;
  logic ld_match;
  logic [PTR_W-1:0] ld_idx;

  // Status and head presentation come straight from registers.
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign drain_valid = !empty;
  assign drain_addr  = empty ? '0 : mem_addr[head];
  assign drain_data  = empty ? '0 : mem_data[head];
  assign drain_id    = empty ? '0 : mem_id[head];
  assign drain_fire  = drain_valid & drain_ready;
  assign enq_fire    = enq_valid & enq_ready;

  // Load lookup walks oldest to youngest so the youngest match wins.
  always_comb begin
    ld_match = 1'b0;
    ld_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_vld[head + PTR_W'(i)] && (mem_addr[head + PTR_W'(i)] == ld_addr)) begin
        ld_match = 1'b1;
        ld_idx   = head + PTR_W'(i);
      end
    end
  end

  assign ld_hit  = ld_valid & ld_match;
  assign ld_data = ld_hit ? mem_data[ld_idx] : '0;
  assign ld_id   = ld_hit ? mem_id[ld_idx]   : '0;

`ifdef WRITE_BUFFER_COALESCE_EN
  logic             co_match;
  logic [PTR_W-1:0] co_idx;
  logic             coal_wr;

  // Youngest valid entry matching the incoming store address.
  always_comb begin
    co_match = 1'b0;
    co_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_vld[head + PTR_W'(i)] && (mem_addr[head + PTR_W'(i)] == enq_addr)) begin
        co_match = 1'b1;
        co_idx   = head + PTR_W'(i);
      end
    end
  end

  // A youngest match at head means head is the only match; if it drains now, allocate instead.
  assign coal_wr   = enq_fire & co_match & !(drain_fire && (co_idx == head));
  assign enq_ready = !full | co_match;
  assign wr_idx    = coal_wr ? co_idx : tail;
`else
  logic coal_wr;
  assign coal_wr   = 1'b0;
  assign enq_ready = !full;
  assign wr_idx    = tail;
`endif

  assign enq_alloc  = enq_fire & !coal_wr;
  assign payload_wr = enq_fire;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      mem_vld <= '0;
    end else begin
      if (drain_fire) begin
        mem_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (enq_alloc) begin
        mem_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(enq_alloc) - CNT_W'(drain_fire);
    end
  end

  // Payload storage; only the valid bits need reset since outputs are gated by them.
  always_ff @(posedge clk) begin
    if (payload_wr) begin
      mem_data[wr_idx] <= enq_data;
      mem_id[wr_idx]   <= enq_id;
      if (enq_alloc) begin
        mem_addr[wr_idx] <= enq_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the buffer contents.
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int IW = 20;
`ifdef WRITE_BUFFER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic [IW-1:0] enq_id;
  logic          drain_valid;
  logic          drain_ready;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;
  logic [IW-1:0] drain_id;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic [IW-1:0] ld_id;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  mem_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_id(enq_id),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_data(drain_data), .drain_id(drain_id),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_id(ld_id),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } ent_t;

  ent_t          q[$];
  logic [IW-1:0] drained[$];
  int checks = 0;
  int failures = 0;
  int dropped_enq = 0;
  int idle_drain = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: q[0] is the oldest store. Compare at negedge with inputs stable, then apply the coming edge.
  always @(negedge clk) begin : cmp
    int n, k;
    bit exp_rdy, hit, dfire, efire;
    logic [DW-1:0] hd;
    logic [IW-1:0] hi;
    ent_t e;
    if (rst) q.delete();
    n = q.size();
    k = -1;
    for (int j = 0; j < n; j++) if (q[j].addr == enq_addr) k = j;
    exp_rdy = (n < DEPTH) || (COAL && k >= 0);
    hit = 1'b0; hd = '0; hi = '0;
    if (ld_valid)
      for (int j = 0; j < n; j++)
        if (q[j].addr == ld_addr) begin hit = 1'b1; hd = q[j].data; hi = q[j].id; end
    check("count", count, n);
    check("empty", empty, n == 0);
    check("full", full, n == DEPTH);
    check("enq_ready", enq_ready, exp_rdy);
    check("drain_valid", drain_valid, n > 0);
    check("drain_addr", drain_addr, n > 0 ? q[0].addr : '0);
    check("drain_data", drain_data, n > 0 ? q[0].data : '0);
    check("drain_id", drain_id, n > 0 ? q[0].id : '0);
    check("ld_hit", ld_hit, hit);
    check("ld_data", ld_data, hd);
    check("ld_id", ld_id, hi);
    if (!rst) begin
      dfire = drain_ready && n > 0;
      efire = enq_valid && exp_rdy;
      if (enq_valid && !exp_rdy) dropped_enq++;
      if (drain_ready && n == 0) idle_drain++;
      if (dfire) drained.push_back(drain_id);
      if (efire && COAL && k >= 0 && !(k == 0 && dfire)) begin
        q[k].data = enq_data;
        q[k].id   = enq_id;
        efire = 1'b0;
      end
      if (dfire) void'(q.pop_front());
      if (efire) begin
        e.addr = enq_addr; e.data = enq_data; e.id = enq_id;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] i);
    enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_id = i;
  endtask

  initial begin
    rst = 1'b1; enq_valid = 0; enq_addr = '0; enq_data = '0; enq_id = '0;
    drain_ready = 0; ld_valid = 0; ld_addr = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_drain_valid", drain_valid, 0);
    tick();

    // Fill to full, offer a non-matching store, then a matching one.
    for (int i = 0; i < 4; i++) begin
      enq(26'h10 + AW'(i), 32'h100 + DW'(i), IW'(i + 1));
      tick();
    end
    enq(26'h14, 32'h777, 20'd8);
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_enq_ready", enq_ready, 0);
    check("fill_count", count, 4);
    tick();
    enq(26'h13, 32'h5, 20'd9);
    @(negedge clk);
    check("coal_enq_ready", enq_ready, COAL ? 1 : 0);
    tick();
    enq_valid = 0;
    @(negedge clk);
    check("coal_count", count, 4);
    tick();
    drain_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_valid_seq", drain_valid, 1);
      check("drain_id_seq", drain_id, (k == 3 && COAL) ? 9 : k + 1);
      if (k == 3) check("drain_data_13", drain_data, COAL ? 32'h5 : 32'h103);
      tick();
    end
    drain_ready = 0;
    @(negedge clk);
    check("drained_empty", empty, 1);
    tick();

    // Forwarding from the youngest match.
    enq(26'h20, 32'hAAAA, 20'd5); tick();
    enq(26'h20, 32'hBBBB, 20'd6); tick();
    enq_valid = 0; ld_valid = 1; ld_addr = 26'h20;
    @(negedge clk);
    check("fwd_hit", ld_hit, 1);
    check("fwd_data", ld_data, 32'hBBBB);
    check("fwd_id", ld_id, 6);
    tick();
    ld_addr = 26'h21;
    @(negedge clk);
    check("fwd_miss_hit", ld_hit, 0);
    check("fwd_miss_data", ld_data, 0);
    tick();
    ld_valid = 0; rst = 1; tick(); rst = 0;

    // Simultaneous enqueue and drain; same-cycle store is not forwarded.
    enq(26'h30, 32'h30, 20'd30); tick();
    enq(26'h31, 32'h31, 20'd31); tick();
    enq(26'h32, 32'h32, 20'd32); drain_ready = 1; ld_valid = 1; ld_addr = 26'h32;
    @(negedge clk);
    check("sim_count", count, 2);
    check("sim_same_cycle_hit", ld_hit, 0);
    tick();
    enq_valid = 0; drain_ready = 0;
    @(negedge clk);
    check("sim_count_after", count, 2);
    check("sim_next_cycle_hit", ld_hit, 1);
    check("sim_next_cycle_id", ld_id, 32);
    tick();

    // Reset asserted mid-drain with three entries.
    ld_valid = 0;
    enq(26'h40, 32'h40, 20'd40); tick();
    enq_valid = 0; drain_ready = 1; ld_valid = 1; ld_addr = 26'h31;
    #1;
    check("pre_rst_count", count, 3);
    check("pre_rst_hit", ld_hit, 1);
    rst = 1; #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_drain_valid", drain_valid, 0);
    check("rst_mid_ld_hit", ld_hit, 0);
    check("rst_mid_enq_ready", enq_ready, 1);
    check("rst_mid_drain_id", drain_id, 0);
    check("rst_mid_ld_data", ld_data, 0);
    tick();
    rst = 0; drain_ready = 0; ld_valid = 0;
    tick();

    // Wrap-around: ten stores with staggered drain_ready.
    drained.delete();
    for (int i = 0; i < 10; i++) begin
      enq(26'h50 + AW'(i), DW'($urandom), IW'(100 + i));
      drain_ready = (i % 3) != 0;
      tick();
    end
    enq_valid = 0; drain_ready = 1;
    for (int k = 0; k < 20 && !empty; k++) tick();
    drain_ready = 0;
    @(negedge clk);
    check("wrap_empty", empty, 1);
    check("wrap_drained_n", drained.size(), 10);
    for (int i = 0; i < drained.size() && i < 10; i++) check("wrap_order", drained[i], 100 + i);
    tick();

    // Randomized traffic over a small address window to provoke matches.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      enq_valid   = $urandom_range(0, 99) < 60;
      enq_addr    = 26'h60 + AW'($urandom_range(0, 7));
      enq_data    = $urandom;
      enq_id      = IW'($urandom);
      drain_ready = $urandom_range(0, 99) < 45;
      ld_valid    = $urandom_range(0, 1) == 1;
      ld_addr     = 26'h60 + AW'($urandom_range(0, 7));
      tick();
    end
    rst = 0; enq_valid = 0; drain_ready = 0; ld_valid = 0;
    tick();

    $display("protocol events: dropped enqueues=%0d, drain_ready while empty=%0d", dropped_enq, idle_drain);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
